huffman_stream_serializer: RTL



---
 rtl/huffman_stream_serializer.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/huffman_stream_serializer.sv
// Huffman output serializer: latches a code table on start, optionally emits it as a
// length/codeword header, then streams each accepted symbol's codeword MSB-first.
module huffman_stream_serializer #(
    parameter int NSYM   = 10,
    parameter int SYM_W  = 4,
    parameter int CODE_W = 9,
    parameter int LEN_W  = 4,
    parameter int HDR_EN = 1
) (
    input  logic                           Clk_in,
    input  logic                           n_Rst,
    input  logic                           Start_out,
    input  logic [NSYM*(LEN_W+CODE_W)-1:0] Code_tbl,
    input  logic [SYM_W-1:0]               sym_data,
    input  logic                           sym_valid,
    input  logic                           sym_last,
    output logic                           sym_ready,
    output logic                           Out,
    output logic                           Outt,
    input  logic                           out_ready,
    output logic                           busy,
    output logic                           Fin,
    output logic                           err,
    output logic [2:0]                     state_dbg
);

    localparam int EW    = LEN_W + CODE_W;
    localparam int TBL_W = NSYM * EW;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_HDR_LEN  = 3'd1;
    localparam logic [2:0] S_HDR_CODE = 3'd2;
    localparam logic [2:0] S_FETCH    = 3'd3;
    localparam logic [2:0] S_DATA     = 3'd4;
    localparam logic [2:0] S_DONE     = 3'd5;

    localparam logic [SYM_W-1:0] K_LAST   = SYM_W'(NSYM - 1);
    localparam logic [SYM_W:0]   NSYM_V   = (SYM_W + 1)'(NSYM);
    localparam logic [LEN_W-1:0] CODE_W_L = LEN_W'(CODE_W);
    localparam logic [LEN_W-1:0] LEN_W_L  = LEN_W'(LEN_W);

    logic [2:0]        state;
    logic [TBL_W-1:0]  tbl;
    logic [SYM_W-1:0]  k;
    logic [LEN_W-1:0]  cnt;
    logic [CODE_W-1:0] code_q;
    logic              last_q;

    logic [EW-1:0]     ent_k;
    logic [EW-1:0]     ent_s;
    logic [LEN_W-1:0]  len_k;
    logic [LEN_W-1:0]  len_s;
    logic [CODE_W-1:0] code_k;
    logic [CODE_W-1:0] code_s;
    logic [LEN_W-1:0]  bit_idx;
    logic              sym_bad;
    logic              xfer;

    // Index compare instead of a variable part-select, so symbols >= NSYM read as zero.
    function automatic logic [EW-1:0] lookup(input logic [SYM_W-1:0] idx,
                                             input logic [TBL_W-1:0] t);
        logic [EW-1:0] e;
        e = '0;
        for (int i = 0; i < NSYM; i++) begin
            if (idx == SYM_W'(i)) e = t[i*EW +: EW];
        end
        return e;
    endfunction

    function automatic logic [LEN_W-1:0] clamp(input logic [LEN_W-1:0] l);
        return (l > CODE_W_L) ? CODE_W_L : l;
    endfunction

    assign ent_k   = lookup(k, tbl);
    assign ent_s   = lookup(sym_data, tbl);
    assign len_k   = ent_k[EW-1 -: LEN_W];
    assign code_k  = ent_k[CODE_W-1:0];
    assign len_s   = ent_s[EW-1 -: LEN_W];
    assign code_s  = ent_s[CODE_W-1:0];
    assign sym_bad = ({1'b0, sym_data} >= NSYM_V) || (len_s == '0);
    assign bit_idx = cnt - 1'b1;

    // Handshakes: a bit moves on a rising edge with Outt && out_ready, a symbol with
    // sym_valid && sym_ready. Out/Outt derive only from registers, so they hold while
    // out_ready is low; cnt counts the transfers still owed in the current field.
    assign Outt      = (state == S_HDR_LEN) || (state == S_HDR_CODE) || (state == S_DATA);
    assign sym_ready = (state == S_FETCH);
    assign busy      = (state != S_IDLE) && (state != S_DONE);
    assign Fin       = (state == S_DONE);
    assign state_dbg = state;
    assign xfer      = Outt && out_ready;

    always_comb begin
        Out = 1'b0;
        case (state)
            S_HDR_LEN:  Out = |(len_k & (LEN_W'(1) << bit_idx));
            S_HDR_CODE: Out = |(code_k & (CODE_W'(1) << bit_idx));
            S_DATA:     Out = |(code_q & (CODE_W'(1) << bit_idx));
            default:    Out = 1'b0;
        endcase
    end

    always_ff @(posedge Clk_in or negedge n_Rst) begin
        if (!n_Rst) begin
            state  <= S_IDLE;
            tbl    <= '0;
            k      <= '0;
            cnt    <= '0;
            code_q <= '0;
            last_q <= 1'b0;
            err    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (Start_out) begin
                        tbl <= Code_tbl;
                        err <= 1'b0;
                        k   <= '0;
                        cnt <= LEN_W_L;
                        state <= (HDR_EN != 0) ? S_HDR_LEN : S_FETCH;
                    end
                end
                S_HDR_LEN: begin
                    if (xfer) begin
                        if (cnt == LEN_W'(1)) begin
                            if (len_k != '0) begin
                                cnt   <= clamp(len_k);
                                state <= S_HDR_CODE;
                                if (len_k > CODE_W_L) err <= 1'b1;
                            end else if (k == K_LAST) begin
                                state <= S_FETCH;
                            end else begin
                                k   <= k + 1'b1;
                                cnt <= LEN_W_L;
                            end
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                end
                S_HDR_CODE: begin
                    if (xfer) begin
                        if (cnt == LEN_W'(1)) begin
                            if (k == K_LAST) begin
                                state <= S_FETCH;
                            end else begin
                                k     <= k + 1'b1;
                                cnt   <= LEN_W_L;
                                state <= S_HDR_LEN;
                            end
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                end
                S_FETCH: begin
                    if (sym_valid) begin
                        if (sym_bad) begin
                            err <= 1'b1;
                            if (sym_last) state <= S_DONE;
                        end else begin
                            code_q <= code_s;
                            last_q <= sym_last;
                            cnt    <= clamp(len_s);
                            state  <= S_DATA;
                            if (len_s > CODE_W_L) err <= 1'b1;
                        end
                    end
                end
                S_DATA: begin
                    if (xfer) begin
                        if (cnt == LEN_W'(1)) begin
                            state <= last_q ? S_DONE : S_FETCH;
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
